result_drain: RTL and testbench

Read-side engine for the results SRAM. The systolic-array path writes one result row per address; this block reads a programmed range of rows back out and streams them on a valid/ready interface to the host/DMA side. A small skid FIFO absorbs the SRAM's one-cycle read latency, so sustained throughput is one row per cycle under back-pressure.

---
 rtl/result_drain.sv | 133 +++++++++++++
 tb/tb_result_drain.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_drain.sv
// Results-SRAM drain engine: reads a programmed row range and streams it on valid/ready.
// Optional RESULT_DRAIN_RELU_EN clamps negative lanes to zero on the FIFO write path.
module result_drain #(
    parameter int ADDRESSSIZE    = 10,
    parameter int PARTIAL_SUM_BW = 24,
    parameter int MATRIX_SIZE    = 127,
    parameter int WORDSIZE       = PARTIAL_SUM_BW * MATRIX_SIZE
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [ADDRESSSIZE-1:0] base_addr,
    input  logic [ADDRESSSIZE:0]   num_rows,
    output logic                   busy,
    output logic                   done,
    output logic                   sram_rd_en,
    output logic [ADDRESSSIZE-1:0] sram_rd_addr,
    input  logic [WORDSIZE-1:0]    sram_rd_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [WORDSIZE-1:0]    m_data,
    output logic                   m_last
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDRESSSIZE:0] ONE = {{ADDRESSSIZE{1'b0}}, 1'b1};

    state_t                 state;
    state_t                 state_nxt;
    logic [ADDRESSSIZE-1:0] base_q;
    logic [ADDRESSSIZE:0]   num_q;
    logic [ADDRESSSIZE:0]   issued;
    logic [ADDRESSSIZE:0]   accepted;
    logic                   inflight;
    logic [1:0]             count;
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [WORDSIZE-1:0]    mem [2];
    logic [WORDSIZE-1:0]    wr_data;
    logic                   push;
    logic                   pop;
    logic                   last_head;
    logic [2:0]             occupancy;

    // A read issued last cycle returns data this cycle; that is the FIFO write.
    assign push      = inflight;
    assign m_valid   = (count != 2'd0);
    assign pop       = m_valid & m_ready;
    assign last_head = (accepted == (num_q - ONE));
    assign m_last    = m_valid & last_head;
    assign m_data    = m_valid ? mem[rd_ptr] : '0;

    // Rows buffered plus rows in flight, less the one leaving this cycle.
    assign occupancy    = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign sram_rd_en   = (state == RUN) && (issued < num_q) && (occupancy < 3'd2);
    assign sram_rd_addr = base_q + issued[ADDRESSSIZE-1:0];

`ifdef RESULT_DRAIN_RELU_EN
    always_comb begin
        wr_data = sram_rd_data;
        for (int i = 0; i < MATRIX_SIZE; i++) begin
            if (sram_rd_data[i*PARTIAL_SUM_BW + PARTIAL_SUM_BW - 1])
                wr_data[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = '0;
        end
    end
`else
    assign wr_data = sram_rd_data;
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = (num_rows == '0) ? DONE : RUN;
            RUN: begin
                busy = 1'b1;
                if (pop && last_head) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            base_q   <= '0;
            num_q    <= '0;
            issued   <= '0;
            accepted <= '0;
            inflight <= 1'b0;
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= sram_rd_en;
            if (state == IDLE && start) begin
                base_q   <= base_addr;
                num_q    <= num_rows;
                issued   <= '0;
                accepted <= '0;
            end else begin
                if (sram_rd_en) issued <= issued + ONE;
                if (pop) accepted <= accepted + ONE;
            end
            if (push) wr_ptr <= ~wr_ptr;
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: row storage has no reset; m_data is gated by m_valid so stale rows never leak.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: tb/tb_result_drain.sv
// Directed self-checking bench for result_drain with a one-cycle-latency SRAM model.
module tb_result_drain;

    localparam int AW = 10;
    localparam int BW = 24;
    localparam int MS = 127;
    localparam int W  = BW * MS;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   num_rows = '0;
    logic          busy;
    logic          done;
    logic          sram_rd_en;
    logic [AW-1:0] sram_rd_addr;
    logic [W-1:0]  sram_rd_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [W-1:0]  m_data;
    logic          m_last;

    int vectors = 0;
    int miscompares = 0;
    bit relu_mode = 1'b0;

    result_drain dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .num_rows(num_rows),
        .busy(busy), .done(done), .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr),
        .sram_rd_data(sram_rd_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    // Lane 0 carries the row address; other lanes add a lane-dependent offset.
    function automatic logic [W-1:0] row_of(input int a);
        logic [W-1:0] r;
        for (int i = 0; i < MS; i++) r[i*BW +: BW] = 24'(a + i * 4096);
        return r;
    endfunction

    function automatic logic [W-1:0] relu_src();
        logic [W-1:0] r;
        for (int i = 0; i < MS; i++) r[i*BW +: BW] = (i % 2 == 0) ? 24'hFFFFFB : 24'h000007;
        return r;
    endfunction

    function automatic logic [W-1:0] relu_exp();
        logic [W-1:0] r;
        for (int i = 0; i < MS; i++) begin
`ifdef RESULT_DRAIN_RELU_EN
            r[i*BW +: BW] = (i % 2 == 0) ? 24'h000000 : 24'h000007;
`else
            r[i*BW +: BW] = (i % 2 == 0) ? 24'hFFFFFB : 24'h000007;
`endif
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (sram_rd_en) sram_rd_data <= relu_mode ? relu_src() : row_of(int'(sram_rd_addr));
    end

    // Returns at the negedge of cycle T0+1, T0 being the edge that samples start.
    task automatic do_start(input logic [AW-1:0] b, input int n);
        @(negedge clk);
        start     = 1'b1;
        base_addr = b;
        num_rows  = 11'(n);
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, done, sram_rd_en, m_valid, m_last} !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 00000", {busy, done, sram_rd_en, m_valid, m_last});
        end
        vectors++;
        if (sram_rd_addr !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_addr: got %0d expected 0", sram_rd_addr);
        end
        vectors++;
        if (m_data !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got low %h expected 0", m_data[63:0]);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    // Full-throughput transfer; optionally pulses a bogus start at cycle 'poke'.
    task automatic test_stream(input logic [AW-1:0] b, input int n, input string name, input int poke);
        logic [4:0]   exp_flags;
        logic [4:0]   act_flags;
        logic [AW-1:0] exp_addr;
        logic [W-1:0] exp_row;
        m_ready = 1'b1;
        do_start(b, n);
        for (int c = 1; c <= n + 4; c++) begin
            if (poke != 0 && c == poke) begin
                start = 1'b1; base_addr = 10'd500; num_rows = 11'd100;
            end
            if (poke != 0 && c == poke + 1) start = 1'b0;
            exp_flags = {c <= n + 2, c == n + 3, c <= n, (c >= 3) && (c <= n + 2), c == n + 2};
            act_flags = {busy, done, sram_rd_en, m_valid, m_last};
            vectors++;
            if (act_flags !== exp_flags) begin
                miscompares++;
                $display("FAIL %s flags cycle %0d: got %b expected %b", name, c, act_flags, exp_flags);
            end
            if (c <= n) begin
                exp_addr = 10'(int'(b) + c - 1);
                vectors++;
                if (sram_rd_addr !== exp_addr) begin
                    miscompares++;
                    $display("FAIL %s addr cycle %0d: got %0d expected %0d", name, c, sram_rd_addr, exp_addr);
                end
            end
            if (c >= 3 && c <= n + 2) begin
                exp_row = row_of((int'(b) + c - 3) % 1024);
                vectors++;
                if (m_data !== exp_row) begin
                    miscompares++;
                    $display("FAIL %s data cycle %0d: got low %h expected low %h",
                             name, c, m_data[63:0], exp_row[63:0]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_basic();
        test_stream(10'd0, 64, "basic", 0);
    endtask

    task automatic test_wrap();
        test_stream(10'd1022, 4, "wrap", 0);
    endtask

    task automatic test_backpressure();
        int           pat[4] = '{1, 0, 0, 1};
        int           delivered = 0;
        int           outstanding = 0;
        bit           seen_done = 1'b0;
        bit           prev_stall = 1'b0;
        logic         popn;
        logic [W-1:0] prev_data = '0;
        logic [W-1:0] exp_row;
        @(negedge clk);
        start = 1'b1; base_addr = 10'd40; num_rows = 11'd8; m_ready = 1'b1;
        for (int k = 1; k <= 100 && !seen_done; k++) begin
            @(negedge clk);
            start   = 1'b0;
            m_ready = (pat[k % 4] != 0);
            if (prev_stall) begin
                vectors++;
                if (!m_valid || m_data !== prev_data) begin
                    miscompares++;
                    $display("FAIL bp_stall cycle %0d: valid %b low %h expected valid 1 low %h",
                             k, m_valid, m_data[63:0], prev_data[63:0]);
                end
            end
            popn = m_valid && m_ready;
            if (sram_rd_en) begin
                vectors++;
                if (outstanding - int'(popn) >= 2) begin
                    miscompares++;
                    $display("FAIL bp_occupancy cycle %0d: read with %0d held, %0d popping, expected < 2 net",
                             k, outstanding, popn);
                end
            end
            if (popn) begin
                exp_row = row_of(40 + delivered);
                vectors++;
                if (m_data !== exp_row || m_last !== (delivered == 7)) begin
                    miscompares++;
                    $display("FAIL bp_row %0d: got low %h last %b expected low %h last %b",
                             delivered, m_data[63:0], m_last, exp_row[63:0], delivered == 7);
                end
                delivered++;
            end
            outstanding += int'(sram_rd_en) - int'(popn);
            if (done) seen_done = 1'b1;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
        vectors++;
        if (!seen_done || delivered != 8) begin
            miscompares++;
            $display("FAIL bp_complete: done %b rows %0d expected done 1 rows 8", seen_done, delivered);
        end
        m_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_len();
        do_start(10'd5, 0);
        vectors++;
        if ({busy, done, sram_rd_en, m_valid, m_last} !== 5'b01000) begin
            miscompares++;
            $display("FAIL zero_done: got %b expected 01000", {busy, done, sram_rd_en, m_valid, m_last});
        end
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            vectors++;
            if ({busy, done, sram_rd_en, m_valid, m_last} !== 5'b00000) begin
                miscompares++;
                $display("FAIL zero_idle cycle %0d: got %b expected 00000", c,
                         {busy, done, sram_rd_en, m_valid, m_last});
            end
        end
        test_stream(10'd10, 4, "busy_start", 2);
    endtask

    task automatic test_reset_mid();
        int pops = 0;
        int guard = 0;
        m_ready = 1'b1;
        do_start(10'd100, 10);
        while (pops < 3 && guard < 20) begin
            if (m_valid && m_ready) pops++;
            @(negedge clk);
            guard++;
        end
        m_ready = 1'b0;
        vectors++;
        if (pops != 3) begin
            miscompares++;
            $display("FAIL rmid_pops: got %0d expected 3", pops);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (m_valid !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rmid_stalled: valid %b busy %b expected 1 1", m_valid, busy);
        end
        rstn = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, done, sram_rd_en, m_valid, m_last} !== 5'b00000 || sram_rd_addr !== 10'd0 || m_data !== '0) begin
            miscompares++;
            $display("FAIL rmid_reset: flags %b addr %0d low %h expected 00000 0 0",
                     {busy, done, sram_rd_en, m_valid, m_last}, sram_rd_addr, m_data[63:0]);
        end
        rstn = 1'b1;
        test_stream(10'd200, 10, "after_reset", 0);
    endtask

    task automatic test_relu();
        logic [W-1:0] exp_row;
        exp_row   = relu_exp();
        relu_mode = 1'b1;
        m_ready   = 1'b1;
        do_start(10'd0, 1);
        repeat (2) @(negedge clk);
        vectors++;
        if (m_valid !== 1'b1 || m_last !== 1'b1 || m_data !== exp_row) begin
            miscompares++;
            $display("FAIL relu_row: valid %b last %b low %h expected 1 1 low %h",
                     m_valid, m_last, m_data[63:0], exp_row[63:0]);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL relu_done: got %b expected 1", done);
        end
        relu_mode = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_reset_mid();
        test_relu();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
